// File: rtl/capture_port_sequencer_if.sv
// RAM port and Nios read handshake bundle for the capture port sequencer.
// The sequencer side (master) drives the RAM address, the write enable and the
// Nios acknowledges. The requester/RAM side (slave) drives the Nios request.
interface capture_port_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              nios_req;
    logic [ADDR_W-1:0] nios_addr;
    logic              nios_ack;
    logic              nios_rvalid;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;

    modport master (
        input  nios_req,
        input  nios_addr,
        output nios_ack,
        output nios_rvalid,
        output ram_addr,
        output ram_wren
    );

    modport slave (
        output nios_req,
        output nios_addr,
        input  nios_ack,
        input  nios_rvalid,
        input  ram_addr,
        input  ram_wren
    );
endinterface

// File: rtl/capture_port_sequencer.sv
// Sequencer for the shared single-address port of the load-circuit sample RAMs.
// It captures one block of ADC samples per request, paced by the ADC
// chip-select strobe. Outside capture, it arbitrates reads between the GUI
// raster scan (priority) and Nios software reads.
module capture_port_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int GUI_STEP = 4,
    parameter int GUI_LAST = 1615
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cs_strobe,
    input  logic                        i_take_sample,
    input  logic                        i_gui_enable,
    capture_port_sequencer_if.master    bus,
    output logic                        o_capture_busy,
    output logic                        o_capture_done,
    output logic [ADDR_W-1:0]           o_sample_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LP_LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] LP_ONE       = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LP_GUI_STEP  = ADDR_W'(GUI_STEP);
    localparam logic [ADDR_W-1:0] LP_GUI_LAST  = ADDR_W'(GUI_LAST);

    logic [1:0]        r_rst_sync;
    logic              w_rst_n;
    logic [1:0]        r_cs_sync;
    logic [1:0]        r_take_sync;
    logic              r_cs_prev;
    state_t            r_state;
    logic [ADDR_W-1:0] r_sample_count;
    logic [ADDR_W-1:0] r_gui_addr;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_wren;
    logic              r_nios_ack;
    logic              r_nios_rvalid;

    logic              w_cs_rise;
    logic              w_take_s;
    logic              w_arb_en;
    state_t            w_state_next;
    logic [ADDR_W-1:0] w_count_next;
    logic [ADDR_W-1:0] w_gui_next;
    logic [ADDR_W-1:0] w_ram_addr_next;
    logic              w_ram_wren_next;
    logic              w_nios_ack_next;

    // Reset asserts immediately but releases only on a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rst_sync <= 2'b00;
        else        r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    // Two-flop synchronisers for the asynchronous strobe and switch, plus the
    // delayed strobe copy used for rising-edge detection.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cs_sync   <= 2'b00;
            r_take_sync <= 2'b00;
            r_cs_prev   <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[0], i_cs_strobe};
            r_take_sync <= {r_take_sync[0], i_take_sample};
            r_cs_prev   <= r_cs_sync[1];
        end
    end

    assign w_cs_rise = r_cs_sync[1] & ~r_cs_prev;
    assign w_take_s  = r_take_sync[1];

    // State, counters and registered RAM-port outputs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state        <= ST_IDLE;
            r_sample_count <= '0;
            r_gui_addr     <= '0;
            r_ram_addr     <= '0;
            r_ram_wren     <= 1'b0;
            r_nios_ack     <= 1'b0;
            r_nios_rvalid  <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_sample_count <= w_count_next;
            r_gui_addr     <= w_gui_next;
            r_ram_addr     <= w_ram_addr_next;
            r_ram_wren     <= w_ram_wren_next;
            r_nios_ack     <= w_nios_ack_next;
            r_nios_rvalid  <= r_nios_ack;
        end
    end

    // GUI raster address: cleared while the read area is inactive, otherwise
    // steps and wraps once it has reached the threshold.
    always_comb begin
        w_gui_next = '0;
        if (i_gui_enable) begin
            if (r_gui_addr >= LP_GUI_LAST) w_gui_next = '0;
            else                           w_gui_next = r_gui_addr + LP_GUI_STEP;
        end
    end

    // Capture sequencing and port arbitration; reads are only served when not
    // capturing, GUI first, and a Nios read is never re-acked while in flight.
    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_sample_count;
        w_ram_addr_next = r_ram_addr;
        w_ram_wren_next = 1'b0;
        w_nios_ack_next = 1'b0;
        w_arb_en        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_arb_en = 1'b1;
                if (w_take_s) begin
                    w_state_next = ST_CAPTURE;
                    w_count_next = '0;
                end
            end
            ST_CAPTURE: begin
                if (!w_take_s) begin
                    // Abort wins over a coincident strobe edge.
                    w_state_next = ST_IDLE;
                    w_count_next = '0;
                end else if (w_cs_rise) begin
                    w_ram_addr_next = r_sample_count;
                    w_ram_wren_next = 1'b1;
                    w_count_next    = r_sample_count + LP_ONE;
                    if (r_sample_count == LP_LAST_ADDR) w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_arb_en = 1'b1;
                if (!w_take_s) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
                w_count_next = '0;
            end
        endcase

        if (w_arb_en) begin
            if (i_gui_enable) begin
                w_ram_addr_next = r_gui_addr;
            end else if (bus.nios_req && !r_nios_ack) begin
                w_ram_addr_next = bus.nios_addr;
                w_nios_ack_next = 1'b1;
            end
        end
    end

    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.nios_ack    = r_nios_ack;
    assign bus.nios_rvalid = r_nios_rvalid;
    assign o_capture_busy  = (r_state == ST_CAPTURE);
    assign o_capture_done  = (r_state == ST_DONE);
    assign o_sample_count  = r_sample_count;

endmodule

// File: tb/tb_capture_port_sequencer.sv
// Scoreboard bench for capture_port_sequencer: stimulus pushes expected RAM
// writes, Nios read addresses and GUI scan addresses into queues; a monitor
// pops and compares whenever the DUT presents a write, an ack or a GUI cycle.
module tb_capture_port_sequencer;
    localparam int AW    = 12;
    localparam int STEP  = 4;
    localparam int LAST  = 1615;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cs = 1'b0;
    logic take = 1'b0;
    logic gui = 1'b0;
    logic busy, done;
    logic [AW-1:0] cnt;

    capture_port_sequencer_if #(.ADDR_W(AW)) bus ();

    capture_port_sequencer #(.ADDR_W(AW), .GUI_STEP(STEP), .GUI_LAST(LAST)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cs_strobe    (cs),
        .i_take_sample  (take),
        .i_gui_enable   (gui),
        .bus            (bus),
        .o_capture_busy (busy),
        .o_capture_done (done),
        .o_sample_count (cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int wr_q[$];
    int nios_q[$];
    int gui_q[$];
    int model_cnt = 0;
    logic mon_ack_prev = 1'b0;
    logic mon_busy_prev = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        checks++;
        errors++;
        $display("FAIL %s: got %0d expected none", name, act);
    endtask

    // Monitor: compares every DUT-presented event against the queues.
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            mon_ack_prev  = 1'b0;
            mon_busy_prev = 1'b0;
        end else begin
            if (bus.ram_wren) begin
                if (wr_q.size() == 0) fail_now("unexpected_write", int'(bus.ram_addr));
                else begin
                    int e;
                    e = wr_q.pop_front();
                    chk("write_addr", int'(bus.ram_addr), e);
                    $display("write addr=%0d exp=%0d", bus.ram_addr, e);
                end
            end
            if (bus.nios_ack) begin
                chk("ack_with_gui_off", int'(gui), 0);
                chk("ack_outside_capture", int'(mon_busy_prev), 0);
                if (nios_q.size() == 0) fail_now("unexpected_ack", int'(bus.ram_addr));
                else begin
                    int e;
                    e = nios_q.pop_front();
                    chk("nios_addr", int'(bus.ram_addr), e);
                    $display("nios ack addr=0x%03h exp=0x%03h", bus.ram_addr, e);
                end
            end
            if (mon_ack_prev) chk("rvalid_after_ack", int'(bus.nios_rvalid), 1);
            else if (bus.nios_rvalid) fail_now("stray_rvalid", 1);
            if (gui) begin
                if (gui_q.size() == 0) fail_now("unexpected_gui_cycle", int'(bus.ram_addr));
                else chk("gui_addr", int'(bus.ram_addr), gui_q.pop_front());
            end
            mon_ack_prev  = bus.nios_ack;
            mon_busy_prev = busy;
        end
    end

    // One strobe pulse with the given period; optionally expects a write at
    // the model's next capture address.
    task automatic cs_edge(input int gap, input bit expect_write);
        if (expect_write) begin
            wr_q.push_back(model_cnt);
            model_cnt = (model_cnt + 1) % DEPTH;
        end
        @(negedge clk);
        cs = 1'b1;
        repeat (gap / 2) @(negedge clk);
        cs = 1'b0;
        repeat (gap - gap / 2 - 1) @(negedge clk);
    endtask

    // GUI read area active for n cycles; expected addresses from the raster rule.
    task automatic gui_scan(input int n);
        int g;
        g = 0;
        for (int i = 0; i < n; i++) begin
            gui_q.push_back(g);
            g = (g >= LAST) ? 0 : g + STEP;
        end
        @(negedge clk);
        gui = 1'b1;
        repeat (n) @(negedge clk);
        gui = 1'b0;
    endtask

    // One Nios read; returns the number of clock edges until ack was seen.
    task automatic nios_read(input int addr, input int limit, output int waited);
        bit got;
        got = 1'b0;
        waited = 0;
        nios_q.push_back(addr);
        @(negedge clk);
        bus.nios_req  = 1'b1;
        bus.nios_addr = AW'(addr);
        while (!got && waited < limit) begin
            @(posedge clk);
            #1;
            waited++;
            if (bus.nios_ack) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL nios_ack_timeout: got no ack after %0d cycles required ack", waited);
            void'(nios_q.pop_back());
        end
        @(negedge clk);
        bus.nios_req = 1'b0;
    endtask

    initial begin
        int n;
        int k;
        bus.nios_req  = 1'b0;
        bus.nios_addr = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ram_addr", int'(bus.ram_addr), 0);
        chk("rst_wren", int'(bus.ram_wren), 0);
        chk("rst_ack", int'(bus.nios_ack), 0);
        chk("rst_rvalid", int'(bus.nios_rvalid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(cnt), 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Random Nios reads in IDLE: ack on the first edge after the request
        for (int i = 0; i < 6; i++) begin
            nios_read(int'($urandom_range(0, DEPTH - 1)), 20, n);
            chk("idle_ack_latency", n, 1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // GUI priority: request during the scan is served right after it ends
        fork
            gui_scan(30);
            begin
                repeat (3) @(negedge clk);
                nios_read('h123, 100, n);
                chk("ack_after_gui_drop", n, 28);
            end
        join

        // Abort after a random number of samples
        take = 1'b1;
        repeat (5) @(negedge clk);
        chk("arm_busy", int'(busy), 1);
        chk("arm_count", int'(cnt), 0);
        model_cnt = 0;
        k = int'($urandom_range(60, 140));
        for (int i = 0; i < k; i++) cs_edge(int'($urandom_range(4, 10)), 1'b1);
        chk("abort_pre_count", int'(cnt), k);
        take = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_count", int'(cnt), 0);
        for (int i = 0; i < 4; i++) cs_edge(6, 1'b0);
        chk("abort_no_writes", wr_q.size(), 0);

        // Re-arm restarts at 0; then strobe and abort arrive together
        take = 1'b1;
        repeat (5) @(negedge clk);
        model_cnt = 0;
        for (int i = 0; i < 3; i++) cs_edge(6, 1'b1);
        @(negedge clk);
        cs = 1'b1;
        take = 1'b0;
        repeat (3) @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        chk("simul_busy", int'(busy), 0);
        chk("simul_done", int'(done), 0);
        chk("simul_count", int'(cnt), 0);

        // Full capture with a Nios request held off until DONE
        take = 1'b1;
        repeat (5) @(negedge clk);
        model_cnt = 0;
        fork
            begin
                for (int i = 0; i < DEPTH; i++) begin
                    cs_edge(8, 1'b1);
                    if (i % 512 == 511) chk("capture_count", int'(cnt), (i + 1) % DEPTH);
                end
            end
            begin
                repeat (200) @(negedge clk);
                nios_read(int'($urandom_range(0, DEPTH - 1)), 40000, n);
            end
        join
        chk("full_busy", int'(busy), 0);
        chk("full_done", int'(done), 1);
        chk("full_count", int'(cnt), 0);
        for (int i = 0; i < 3; i++) cs_edge(6, 1'b0);
        chk("no_recapture_done", int'(done), 1);
        chk("no_recapture_count", int'(cnt), 0);

        // GUI scan across the wrap, then restart from 0
        gui_scan(410);
        repeat (2) @(negedge clk);
        gui_scan(3);

        // Mixed GUI bursts and Nios reads in DONE
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1) gui_scan(int'($urandom_range(1, 20)));
            nios_read(int'($urandom_range(0, DEPTH - 1)), 20, n);
            chk("done_ack_latency", n, 1);
        end

        // Reset asserted in the middle of a capture
        take = 1'b0;
        repeat (5) @(negedge clk);
        chk("leave_done", int'(done), 0);
        take = 1'b1;
        repeat (5) @(negedge clk);
        model_cnt = 0;
        for (int i = 0; i < 20; i++) cs_edge(6, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_count", int'(cnt), 0);
        chk("midrst_wren", int'(bus.ram_wren), 0);
        chk("midrst_addr", int'(bus.ram_addr), 0);
        chk("midrst_ack", int'(bus.nios_ack), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_busy", int'(busy), 1);
        chk("post_rst_count", int'(cnt), 0);
        model_cnt = 0;
        cs_edge(6, 1'b1);
        cs_edge(6, 1'b1);
        chk("post_rst_count2", int'(cnt), 2);

        repeat (5) @(negedge clk);
        chk("writes_drained", wr_q.size(), 0);
        chk("nios_drained", nios_q.size(), 0);
        chk("gui_drained", gui_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
